vram_responder: RTL and testbench

Memory-side responder for the PPU fetch interface.
- Serves pixel-fetcher read requests (16-bit address plus level-valid) from the single-port VRAM BRAM, returning one data byte with a one-cycle valid pulse.
- Arbitrates CPU reads and writes against PPU fetches into the same BRAM.
- Sits between the pixel pipeline's memory port and the VRAM BRAM in the PPU top level.

---
 rtl/ppu_pkg.sv | 42 ++++
 rtl/pipeline.sv | 51 +++++
 rtl/vram_responder.sv | 242 ++++++++++++++++++++++++
 tb/tb_vram_responder.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ppu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ppu_pkg (package)
// Description : Shared constants and types for the PPU memory-side logic.
//               - VRAM window defaults (base address and size)
//               - STAT mode encodings
//               - vram_responder state encoding
//               - open-bus value returned for unmapped or locked accesses
//               - address window helper
// Revision    : 1.0 - initial release
// ============================================================================
package ppu_pkg;

    localparam logic [15:0] VRAM_BASE_DEFAULT = 16'h8000;
    localparam int          VRAM_SIZE_DEFAULT = 8192;

    localparam logic [1:0]  MODE_HBLANK = 2'd0;
    localparam logic [1:0]  MODE_VBLANK = 2'd1;
    localparam logic [1:0]  MODE_OAM    = 2'd2;
    localparam logic [1:0]  MODE_DRAW   = 2'd3;

    localparam logic [7:0]  OPEN_BUS    = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PPU_RD  = 2'd1,
        ST_CPU_RD  = 2'd2,
        ST_RECOVER = 2'd3
    } resp_state_t;

    // True when addr lies in [base, limit). limit is one bit wider so a
    // window ending exactly at 16'hFFFF+1 is still representable.
    function automatic logic addr_in_range(
        input logic [15:0] addr,
        input logic [15:0] base,
        input logic [16:0] limit
    );
        return ({1'b0, addr} >= {1'b0, base}) && ({1'b0, addr} < limit);
    endfunction

endpackage : ppu_pkg
`default_nettype wire

// File: rtl/pipeline.sv
`default_nettype none
// ============================================================================
// Module      : Pipeline
// Description : Fixed-depth register delay line with asynchronous active-high
//               reset. Output equals the input delayed by STAGES clocks.
// Ports       : clk     - clock
//               rst     - asynchronous active-high reset (clears all stages)
//               i_data  - WIDTH-bit input
//               o_data  - WIDTH-bit output, delayed by STAGES cycles
// Parameters  : WIDTH  - data width (>= 1)
//               STAGES - delay in cycles (>= 1)
// Revision    : 1.0 - initial release
// ============================================================================
module Pipeline #(
    parameter int WIDTH  = 2,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data
);

    logic [WIDTH-1:0] r_stage [STAGES];

    generate
        for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
            if (gi == 0) begin : g_first
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        r_stage[gi] <= '0;
                    end else begin
                        r_stage[gi] <= i_data;
                    end
                end
            end else begin : g_rest
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        r_stage[gi] <= '0;
                    end else begin
                        r_stage[gi] <= r_stage[gi-1];
                    end
                end
            end
        end
    endgenerate

    assign o_data = r_stage[STAGES-1];

endmodule : Pipeline
`default_nettype wire

// File: rtl/vram_responder.sv
`default_nettype none
// ============================================================================
// Module      : vram_responder
// Description : Memory-side responder between the PPU pixel fetcher, the CPU
//               and a single-port VRAM BRAM. One access is in flight at a
//               time; the PPU has priority in IDLE, the CPU waits otherwise.
//               Out-of-window accesses never touch the BRAM and return 8'hFF.
// Optional    : VRAM_LOCK_EN - when defined, CPU accesses during pixel
//               transfer (lcd_on_in=1, ppu_mode_in=3) are answered at t+1
//               without BRAM access (reads return 8'hFF, writes dropped).
// Ports       : clk_in, rst_in (async, active-high)
//               ppu_addr_in/ppu_addr_valid_in -> ppu_data_out/ppu_data_valid_out
//               cpu_addr_in/cpu_rd_in/cpu_wr_in/cpu_wdata_in
//                                              -> cpu_rdata_out/cpu_ack_out
//               ppu_mode_in, lcd_on_in         - STAT mode / LCDC.7
//               bram_addr_out/en/we/wdata, bram_rdata_in - BRAM port
// Parameters  : READ_LATENCY (1..4), VRAM_BASE, VRAM_SIZE
// Revision    : 1.0 - initial release
// ============================================================================
module vram_responder
    import ppu_pkg::*;
#(
    parameter int          READ_LATENCY = 2,
    parameter logic [15:0] VRAM_BASE    = VRAM_BASE_DEFAULT,
    parameter int          VRAM_SIZE    = VRAM_SIZE_DEFAULT
) (
    input  logic                         clk_in,
    input  logic                         rst_in,
    input  logic [15:0]                  ppu_addr_in,
    input  logic                         ppu_addr_valid_in,
    output logic [7:0]                   ppu_data_out,
    output logic                         ppu_data_valid_out,
    input  logic [15:0]                  cpu_addr_in,
    input  logic                         cpu_rd_in,
    input  logic                         cpu_wr_in,
    input  logic [7:0]                   cpu_wdata_in,
    output logic [7:0]                   cpu_rdata_out,
    output logic                         cpu_ack_out,
    input  logic [1:0]                   ppu_mode_in,
    input  logic                         lcd_on_in,
    output logic [$clog2(VRAM_SIZE)-1:0] bram_addr_out,
    output logic                         bram_en_out,
    output logic                         bram_we_out,
    output logic [7:0]                   bram_wdata_out,
    input  logic [7:0]                   bram_rdata_in
);

    localparam int              AW             = $clog2(VRAM_SIZE);
    localparam int              CW             = $clog2(READ_LATENCY + 1);
    localparam logic [16:0]     c_ADDR_LIMIT   = {1'b0, VRAM_BASE} + 17'(VRAM_SIZE);
    localparam logic [CW-1:0]   c_CNT_ONE      = CW'(1);
    localparam logic [CW-1:0]   c_CNT_LAST     = CW'(READ_LATENCY);

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    resp_state_t   r_state;
    resp_state_t   w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic          r_oor;          // in-flight read targets an unmapped address
    logic [7:0]    r_ppu_data;
    logic          r_ppu_valid;
    logic [7:0]    r_cpu_rdata;
    logic          r_cpu_ack;

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    logic          w_ppu_in_range;
    logic          w_cpu_in_range;
    logic [AW-1:0] w_ppu_off;
    logic [AW-1:0] w_cpu_off;
    logic          w_cpu_req;
    logic          w_draw_mode;
    logic          w_locked;

    assign w_ppu_in_range = addr_in_range(ppu_addr_in, VRAM_BASE, c_ADDR_LIMIT);
    assign w_cpu_in_range = addr_in_range(cpu_addr_in, VRAM_BASE, c_ADDR_LIMIT);
    assign w_ppu_off      = AW'(ppu_addr_in - VRAM_BASE);
    assign w_cpu_off      = AW'(cpu_addr_in - VRAM_BASE);
    // A CPU request with both strobes high is malformed and never accepted.
    assign w_cpu_req      = cpu_rd_in ^ cpu_wr_in;
    assign w_draw_mode    = lcd_on_in && (ppu_mode_in == MODE_DRAW);

`ifdef VRAM_LOCK_EN
    assign w_locked = w_draw_mode;
`else
    // Mode inputs are decoded in every build so the port behaviour is the
    // same shape; without the lock feature the result never gates the CPU.
    assign w_locked = w_draw_mode & 1'b0;
`endif

    // ------------------------------------------------------------------
    // Accept strobes and BRAM drive (combinational, valid in accept cycle)
    // ------------------------------------------------------------------
    logic          w_acc_ppu;
    logic          w_acc_cpu_rd;
    logic          w_acc_cpu_fast;   // write or locked access, acked at t+1
    logic          w_acc_oor;
    logic          w_bram_en;
    logic          w_bram_we;
    logic [AW-1:0] w_bram_addr;
    logic [7:0]    w_bram_wdata;
    logic          w_cnt_last;

    assign w_cnt_last = (r_cnt == c_CNT_LAST);

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_acc_ppu      = 1'b0;
        w_acc_cpu_rd   = 1'b0;
        w_acc_cpu_fast = 1'b0;
        w_acc_oor      = 1'b0;
        w_bram_en      = 1'b0;
        w_bram_we      = 1'b0;
        w_bram_addr    = '0;
        w_bram_wdata   = '0;
        case (r_state)
            ST_IDLE: begin
                // BRAM strobes are combinational from IDLE, so they are
                // gated by reset to drop the instant reset asserts.
                if (!rst_in) begin
                    if (ppu_addr_valid_in) begin
                        w_acc_ppu   = 1'b1;
                        w_acc_oor   = !w_ppu_in_range;
                        w_bram_en   = w_ppu_in_range;
                        w_bram_addr = w_ppu_in_range ? w_ppu_off : '0;
                        w_state_nxt = ST_PPU_RD;
                    end else if (w_cpu_req) begin
                        if (cpu_wr_in || w_locked) begin
                            w_acc_cpu_fast = 1'b1;
                            w_state_nxt    = ST_RECOVER;
                            if (cpu_wr_in && w_cpu_in_range && !w_locked) begin
                                w_bram_en    = 1'b1;
                                w_bram_we    = 1'b1;
                                w_bram_addr  = w_cpu_off;
                                w_bram_wdata = cpu_wdata_in;
                            end
                        end else begin
                            w_acc_cpu_rd = 1'b1;
                            w_acc_oor    = !w_cpu_in_range;
                            w_bram_en    = w_cpu_in_range;
                            w_bram_addr  = w_cpu_in_range ? w_cpu_off : '0;
                            w_state_nxt  = ST_CPU_RD;
                        end
                    end
                end
            end
            ST_PPU_RD, ST_CPU_RD: begin
                if (w_cnt_last) begin
                    w_state_nxt = ST_RECOVER;
                end
            end
            ST_RECOVER: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Requester tags travel with the BRAM latency; they emerge exactly in
    // the cycle the BRAM data for that request is valid.
    // ------------------------------------------------------------------
    logic [1:0] w_tag_out;

    Pipeline #(
        .WIDTH  (2),
        .STAGES (READ_LATENCY)
    ) u_tag_pipe (
        .clk    (clk_in),
        .rst    (rst_in),
        .i_data ({w_acc_ppu, w_acc_cpu_rd}),
        .o_data (w_tag_out)
    );

    logic w_ppu_done;
    logic w_cpu_rd_done;

    assign w_ppu_done    = (r_state == ST_PPU_RD) && w_cnt_last && w_tag_out[1];
    assign w_cpu_rd_done = (r_state == ST_CPU_RD) && w_cnt_last && w_tag_out[0];

    // ------------------------------------------------------------------
    // Latency counter and response registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_cnt       <= '0;
            r_oor       <= 1'b0;
            r_ppu_data  <= '0;
            r_ppu_valid <= 1'b0;
            r_cpu_rdata <= '0;
            r_cpu_ack   <= 1'b0;
        end else begin
            // Counter runs 1..READ_LATENCY inside a read state, then clears;
            // it therefore never exceeds READ_LATENCY and never wraps.
            if (w_acc_ppu || w_acc_cpu_rd) begin
                r_cnt <= c_CNT_ONE;
                r_oor <= w_acc_oor;
            end else if ((r_state == ST_PPU_RD) || (r_state == ST_CPU_RD)) begin
                r_cnt <= w_cnt_last ? '0 : (r_cnt + c_CNT_ONE);
            end

            r_ppu_valid <= w_ppu_done;
            if (w_ppu_done) begin
                r_ppu_data <= r_oor ? OPEN_BUS : bram_rdata_in;
            end

            r_cpu_ack <= w_cpu_rd_done | w_acc_cpu_fast;
            if (w_cpu_rd_done) begin
                r_cpu_rdata <= r_oor ? OPEN_BUS : bram_rdata_in;
            end else if (w_acc_cpu_fast && cpu_rd_in) begin
                // Only a locked read takes the fast path with rd high.
                r_cpu_rdata <= OPEN_BUS;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign ppu_data_out       = r_ppu_data;
    assign ppu_data_valid_out = r_ppu_valid;
    assign cpu_rdata_out      = r_cpu_rdata;
    assign cpu_ack_out        = r_cpu_ack;
    assign bram_addr_out      = w_bram_addr;
    assign bram_en_out        = w_bram_en;
    assign bram_we_out        = w_bram_we;
    assign bram_wdata_out     = w_bram_wdata;

endmodule : vram_responder
`default_nettype wire

// File: tb/tb_vram_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_vram_responder
// Description : Directed self-checking bench for vram_responder with a
//               behavioural 2-cycle-latency BRAM model. Covers reset, PPU
//               read timing/throughput, PPU/CPU arbitration with write and
//               readback, out-of-window accesses, the VRAM_LOCK_EN option,
//               reset mid-read and a malformed CPU request.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vram_responder;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic [15:0] ppu_addr_in;
    logic        ppu_addr_valid_in;
    logic [7:0]  ppu_data_out;
    logic        ppu_data_valid_out;
    logic [15:0] cpu_addr_in;
    logic        cpu_rd_in;
    logic        cpu_wr_in;
    logic [7:0]  cpu_wdata_in;
    logic [7:0]  cpu_rdata_out;
    logic        cpu_ack_out;
    logic [1:0]  ppu_mode_in;
    logic        lcd_on_in;
    logic [12:0] bram_addr_out;
    logic        bram_en_out;
    logic        bram_we_out;
    logic [7:0]  bram_wdata_out;
    logic [7:0]  bram_rdata_in;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk_in = ~clk_in;

    vram_responder #(
        .READ_LATENCY (2),
        .VRAM_BASE    (16'h8000),
        .VRAM_SIZE    (8192)
    ) dut (
        .clk_in             (clk_in),
        .rst_in             (rst_in),
        .ppu_addr_in        (ppu_addr_in),
        .ppu_addr_valid_in  (ppu_addr_valid_in),
        .ppu_data_out       (ppu_data_out),
        .ppu_data_valid_out (ppu_data_valid_out),
        .cpu_addr_in        (cpu_addr_in),
        .cpu_rd_in          (cpu_rd_in),
        .cpu_wr_in          (cpu_wr_in),
        .cpu_wdata_in       (cpu_wdata_in),
        .cpu_rdata_out      (cpu_rdata_out),
        .cpu_ack_out        (cpu_ack_out),
        .ppu_mode_in        (ppu_mode_in),
        .lcd_on_in          (lcd_on_in),
        .bram_addr_out      (bram_addr_out),
        .bram_en_out        (bram_en_out),
        .bram_we_out        (bram_we_out),
        .bram_wdata_out     (bram_wdata_out),
        .bram_rdata_in      (bram_rdata_in)
    );

    // Behavioural BRAM: enable in cycle t -> data valid during cycle t+2.
    logic [7:0] mem [8192];
    logic [7:0] r_bram_p1 = 8'h00;

    initial bram_rdata_in = 8'h00;

    always @(posedge clk_in) begin
        if (bram_en_out && bram_we_out) mem[bram_addr_out] <= bram_wdata_out;
        if (bram_en_out && !bram_we_out) r_bram_p1 <= mem[bram_addr_out];
        bram_rdata_in <= r_bram_p1;
    end

    // Move to 2 time units after the next n rising edges.
    task automatic step(input int n);
        repeat (n) @(posedge clk_in);
        #2;
    endtask

    task automatic test_reset();
        ppu_addr_valid_in = 1'b1;
        ppu_addr_in       = 16'h8010;
        step(2);
        #1;
        n_total++;
        if ({ppu_data_out, ppu_data_valid_out, cpu_rdata_out, cpu_ack_out,
             bram_addr_out, bram_en_out, bram_we_out, bram_wdata_out} !== '0)
            $display("FAIL reset_outputs: got data=%h v=%b rdata=%h ack=%b addr=%h en=%b we=%b wd=%h, required all 0",
                     ppu_data_out, ppu_data_valid_out, cpu_rdata_out, cpu_ack_out,
                     bram_addr_out, bram_en_out, bram_we_out, bram_wdata_out);
        else n_pass++;
        ppu_addr_valid_in = 1'b0;
        rst_in            = 1'b0;
    endtask

    task automatic test_ppu_read();
        step(1);                       // t
        ppu_addr_in = 16'h8010; ppu_addr_valid_in = 1'b1; #1;
        n_total++;
        if (bram_en_out !== 1'b1 || bram_addr_out !== 13'd16 || bram_we_out !== 1'b0)
            $display("FAIL ppu_accept: got en=%b addr=%0d we=%b, required en=1 addr=16 we=0",
                     bram_en_out, bram_addr_out, bram_we_out);
        else n_pass++;
        step(2);                       // t+2
        n_total++;
        if (ppu_data_valid_out !== 1'b0)
            $display("FAIL ppu_no_early_pulse: got valid=%b, required 0", ppu_data_valid_out);
        else n_pass++;
        step(1);                       // t+3
        n_total++;
        if (ppu_data_valid_out !== 1'b1 || ppu_data_out !== 8'hA5)
            $display("FAIL ppu_pulse: got valid=%b data=%h, required 1 A5", ppu_data_valid_out, ppu_data_out);
        else n_pass++;
        n_total++;
        if (bram_en_out !== 1'b0)
            $display("FAIL ppu_no_accept_in_pulse: got en=%b, required 0", bram_en_out);
        else n_pass++;
        step(1);                       // t+4: next accept with valid held
        n_total++;
        if (bram_en_out !== 1'b1 || ppu_data_valid_out !== 1'b0)
            $display("FAIL ppu_reaccept: got en=%b valid=%b, required en=1 valid=0", bram_en_out, ppu_data_valid_out);
        else n_pass++;
        step(1);                       // t+5: valid drops mid-read
        ppu_addr_valid_in = 1'b0;
        step(2);                       // t+7
        n_total++;
        if (ppu_data_valid_out !== 1'b1 || ppu_data_out !== 8'hA5)
            $display("FAIL ppu_second_pulse: got valid=%b data=%h, required 1 A5", ppu_data_valid_out, ppu_data_out);
        else n_pass++;
    endtask

    task automatic test_arbitration();
        step(1);                       // t
        ppu_addr_in = 16'h9800; ppu_addr_valid_in = 1'b1;
        cpu_addr_in = 16'h8000; cpu_wr_in = 1'b1; cpu_wdata_in = 8'h3C; #1;
        n_total++;
        if (bram_en_out !== 1'b1 || bram_we_out !== 1'b0 || bram_addr_out !== 13'h1800)
            $display("FAIL arb_ppu_first: got en=%b we=%b addr=%h, required en=1 we=0 addr=1800",
                     bram_en_out, bram_we_out, bram_addr_out);
        else n_pass++;
        step(1);                       // t+1
        ppu_addr_valid_in = 1'b0;
        step(2);                       // t+3
        n_total++;
        if (ppu_data_valid_out !== 1'b1 || ppu_data_out !== 8'h5A || cpu_ack_out !== 1'b0)
            $display("FAIL arb_ppu_pulse: got valid=%b data=%h ack=%b, required 1 5A 0",
                     ppu_data_valid_out, ppu_data_out, cpu_ack_out);
        else n_pass++;
        step(1);                       // t+4
        n_total++;
        if (bram_en_out !== 1'b1 || bram_we_out !== 1'b1 || bram_addr_out !== 13'd0 || bram_wdata_out !== 8'h3C)
            $display("FAIL arb_cpu_write: got en=%b we=%b addr=%h wd=%h, required 1 1 0 3C",
                     bram_en_out, bram_we_out, bram_addr_out, bram_wdata_out);
        else n_pass++;
        step(1);                       // t+5
        n_total++;
        if (cpu_ack_out !== 1'b1)
            $display("FAIL arb_write_ack: got ack=%b, required 1", cpu_ack_out);
        else n_pass++;
        cpu_wr_in = 1'b0;
        step(1);                       // t+6: readback
        cpu_rd_in = 1'b1; #1;
        n_total++;
        if (bram_en_out !== 1'b1 || bram_we_out !== 1'b0 || bram_addr_out !== 13'd0)
            $display("FAIL arb_readback_accept: got en=%b we=%b addr=%h, required 1 0 0",
                     bram_en_out, bram_we_out, bram_addr_out);
        else n_pass++;
        step(3);                       // t+9
        n_total++;
        if (cpu_ack_out !== 1'b1 || cpu_rdata_out !== 8'h3C)
            $display("FAIL arb_readback: got ack=%b rdata=%h, required 1 3C", cpu_ack_out, cpu_rdata_out);
        else n_pass++;
        cpu_rd_in = 1'b0;
    endtask

    task automatic test_out_of_range();
        step(1);                       // t
        ppu_addr_in = 16'hFE00; ppu_addr_valid_in = 1'b1; #1;
        n_total++;
        if (bram_en_out !== 1'b0)
            $display("FAIL oor_no_enable: got en=%b, required 0", bram_en_out);
        else n_pass++;
        step(1);
        ppu_addr_valid_in = 1'b0;
        step(2);                       // t+3
        n_total++;
        if (ppu_data_valid_out !== 1'b1 || ppu_data_out !== 8'hFF)
            $display("FAIL oor_ppu_pulse: got valid=%b data=%h, required 1 FF", ppu_data_valid_out, ppu_data_out);
        else n_pass++;
        step(1);                       // t+4 IDLE: CPU write below window
        cpu_addr_in = 16'h7FFF; cpu_wdata_in = 8'h99; cpu_wr_in = 1'b1; #1;
        n_total++;
        if (bram_en_out !== 1'b0 || bram_we_out !== 1'b0)
            $display("FAIL oor_write_dropped: got en=%b we=%b, required 0 0", bram_en_out, bram_we_out);
        else n_pass++;
        step(1);
        n_total++;
        if (cpu_ack_out !== 1'b1)
            $display("FAIL oor_write_ack: got ack=%b, required 1", cpu_ack_out);
        else n_pass++;
        cpu_wr_in = 1'b0;
    endtask

    task automatic test_vram_lock();
`ifdef VRAM_LOCK_EN
        step(1);                       // t
        lcd_on_in = 1'b1; ppu_mode_in = 2'd3;
        cpu_addr_in = 16'h8000; cpu_rd_in = 1'b1; #1;
        n_total++;
        if (bram_en_out !== 1'b0)
            $display("FAIL lock_read_no_enable: got en=%b, required 0", bram_en_out);
        else n_pass++;
        step(1);                       // t+1
        n_total++;
        if (cpu_ack_out !== 1'b1 || cpu_rdata_out !== 8'hFF)
            $display("FAIL lock_read_ack: got ack=%b rdata=%h, required 1 FF", cpu_ack_out, cpu_rdata_out);
        else n_pass++;
        cpu_rd_in = 1'b0;
        step(1);                       // t+2 IDLE
        cpu_wr_in = 1'b1; cpu_wdata_in = 8'h77; #1;
        n_total++;
        if (bram_en_out !== 1'b0 || bram_we_out !== 1'b0)
            $display("FAIL lock_write_dropped: got en=%b we=%b, required 0 0", bram_en_out, bram_we_out);
        else n_pass++;
        step(1);                       // t+3
        n_total++;
        if (cpu_ack_out !== 1'b1)
            $display("FAIL lock_write_ack: got ack=%b, required 1", cpu_ack_out);
        else n_pass++;
        cpu_wr_in = 1'b0;
        step(1);                       // t+4 IDLE, HBLANK
        ppu_mode_in = 2'd0; cpu_rd_in = 1'b1; #1;
        n_total++;
        if (bram_en_out !== 1'b1 || bram_addr_out !== 13'd0)
            $display("FAIL unlock_read_accept: got en=%b addr=%h, required 1 0", bram_en_out, bram_addr_out);
        else n_pass++;
        step(3);
        n_total++;
        if (cpu_ack_out !== 1'b1 || cpu_rdata_out !== 8'h3C)
            $display("FAIL unlock_read: got ack=%b rdata=%h, required 1 3C", cpu_ack_out, cpu_rdata_out);
        else n_pass++;
        cpu_rd_in = 1'b0;
`else
        step(1);                       // t: no lock in this build
        lcd_on_in = 1'b1; ppu_mode_in = 2'd3;
        cpu_addr_in = 16'h8000; cpu_rd_in = 1'b1; #1;
        n_total++;
        if (bram_en_out !== 1'b1 || bram_addr_out !== 13'd0)
            $display("FAIL nolock_read_accept: got en=%b addr=%h, required 1 0", bram_en_out, bram_addr_out);
        else n_pass++;
        step(3);
        n_total++;
        if (cpu_ack_out !== 1'b1 || cpu_rdata_out !== 8'h3C)
            $display("FAIL nolock_read: got ack=%b rdata=%h, required 1 3C", cpu_ack_out, cpu_rdata_out);
        else n_pass++;
        cpu_rd_in = 1'b0;
`endif
        lcd_on_in = 1'b0; ppu_mode_in = 2'd0;
    endtask

    task automatic test_reset_mid_read();
        step(1);                       // t
        ppu_addr_in = 16'h8010; ppu_addr_valid_in = 1'b1;
        step(1);                       // t+1
        rst_in = 1'b1; #1;
        n_total++;
        if ({ppu_data_out, ppu_data_valid_out, cpu_rdata_out, cpu_ack_out,
             bram_addr_out, bram_en_out, bram_we_out, bram_wdata_out} !== '0)
            $display("FAIL midreset_outputs: got data=%h v=%b rdata=%h ack=%b addr=%h en=%b we=%b wd=%h, required all 0",
                     ppu_data_out, ppu_data_valid_out, cpu_rdata_out, cpu_ack_out,
                     bram_addr_out, bram_en_out, bram_we_out, bram_wdata_out);
        else n_pass++;
        ppu_addr_valid_in = 1'b0;
        step(1);
        rst_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step(1);
            n_total++;
            if (ppu_data_valid_out !== 1'b0 || ppu_data_out !== 8'h00)
                $display("FAIL midreset_no_pulse[%0d]: got valid=%b data=%h, required 0 00",
                         i, ppu_data_valid_out, ppu_data_out);
            else n_pass++;
        end
        step(1);                       // fresh request
        ppu_addr_valid_in = 1'b1; #1;
        n_total++;
        if (bram_en_out !== 1'b1 || bram_addr_out !== 13'd16)
            $display("FAIL postreset_accept: got en=%b addr=%0d, required 1 16", bram_en_out, bram_addr_out);
        else n_pass++;
        step(1);
        ppu_addr_valid_in = 1'b0;
        step(2);
        n_total++;
        if (ppu_data_valid_out !== 1'b1 || ppu_data_out !== 8'hA5)
            $display("FAIL postreset_pulse: got valid=%b data=%h, required 1 A5", ppu_data_valid_out, ppu_data_out);
        else n_pass++;
    endtask

    task automatic test_rd_wr_conflict();
        step(1);
        cpu_addr_in = 16'h8010; cpu_rd_in = 1'b1; cpu_wr_in = 1'b1; #1;
        n_total++;
        if (bram_en_out !== 1'b0)
            $display("FAIL conflict_no_accept: got en=%b, required 0", bram_en_out);
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            step(1);
            n_total++;
            if (cpu_ack_out !== 1'b0 || bram_en_out !== 1'b0)
                $display("FAIL conflict_idle[%0d]: got ack=%b en=%b, required 0 0", i, cpu_ack_out, bram_en_out);
            else n_pass++;
        end
        step(1);                       // accept once wr drops
        cpu_wr_in = 1'b0; #1;
        n_total++;
        if (bram_en_out !== 1'b1 || bram_addr_out !== 13'd16 || bram_we_out !== 1'b0)
            $display("FAIL conflict_read_accept: got en=%b addr=%0d we=%b, required 1 16 0",
                     bram_en_out, bram_addr_out, bram_we_out);
        else n_pass++;
        step(3);
        n_total++;
        if (cpu_ack_out !== 1'b1 || cpu_rdata_out !== 8'hA5)
            $display("FAIL conflict_read: got ack=%b rdata=%h, required 1 A5", cpu_ack_out, cpu_rdata_out);
        else n_pass++;
        cpu_rd_in = 1'b0;
        step(1);
    endtask

    initial begin
        rst_in            = 1'b1;
        ppu_addr_in       = 16'h0000;
        ppu_addr_valid_in = 1'b0;
        cpu_addr_in       = 16'h0000;
        cpu_rd_in         = 1'b0;
        cpu_wr_in         = 1'b0;
        cpu_wdata_in      = 8'h00;
        ppu_mode_in       = 2'd0;
        lcd_on_in         = 1'b0;
        for (int i = 0; i < 8192; i++) mem[i] = 8'(i * 7);
        mem[0]      = 8'h00;
        mem[16]     = 8'hA5;
        mem[13'h1800] = 8'h5A;

        test_reset();
        test_ppu_read();
        test_arbitration();
        test_out_of_range();
        test_vram_lock();
        test_reset_mid_read();
        test_rd_wr_conflict();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_vram_responder
`default_nettype wire
